// File: rtl/vl_pkg.sv
// vl_pkg: shared definitions for the vector strip sequencer.
//   - vtype field width and SEW/LMUL encodings with legality helpers
//   - sequencer state enum
//   - default VLEN
package vl_pkg;

  localparam int unsigned VlenDefault = 64;
  localparam int unsigned VtypeFieldW = 3;

  // SEW encodings; 4..7 are reserved.
  localparam logic [VtypeFieldW-1:0] SewE8  = 3'd0;
  localparam logic [VtypeFieldW-1:0] SewE16 = 3'd1;
  localparam logic [VtypeFieldW-1:0] SewE32 = 3'd2;
  localparam logic [VtypeFieldW-1:0] SewE64 = 3'd3;

  // LMUL encodings; 4..7 would be fractional LMUL, which is not supported.
  localparam logic [VtypeFieldW-1:0] LmulM1 = 3'd0;
  localparam logic [VtypeFieldW-1:0] LmulM2 = 3'd1;
  localparam logic [VtypeFieldW-1:0] LmulM4 = 3'd2;
  localparam logic [VtypeFieldW-1:0] LmulM8 = 3'd3;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } vl_state_e;

  function automatic logic sew_legal(input logic [VtypeFieldW-1:0] sew);
    return sew <= SewE64;
  endfunction

  function automatic logic lmul_legal(input logic [VtypeFieldW-1:0] lmul);
    return lmul <= LmulM8;
  endfunction

endpackage

// File: rtl/vl_strip_sequencer_if.sv
// vl_strip_sequencer_if: request and strip-issue signals of the strip sequencer.
//   master: request source / strip consumer (drives req_*, iss_ready)
//   slave : the sequencer (drives req_ready, iss_*, done, err)
interface vl_strip_sequencer_if
  import vl_pkg::*;
#(
  parameter int unsigned AVL_W = 8,
  parameter int unsigned IDX_W = 4
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic [VtypeFieldW-1:0] req_sew;
  logic [VtypeFieldW-1:0] req_lmul;
  logic [AVL_W-1:0]       req_avl;

  logic                   iss_valid;
  logic                   iss_ready;
  logic [AVL_W-1:0]       iss_vl;
  logic                   iss_last;
  logic [IDX_W-1:0]       iss_idx;

  logic                   done;
  logic                   err;

  modport master (
    output req_valid, req_sew, req_lmul, req_avl, iss_ready,
    input  req_ready, iss_valid, iss_vl, iss_last, iss_idx, done, err
  );

  modport slave (
    input  req_valid, req_sew, req_lmul, req_avl, iss_ready,
    output req_ready, iss_valid, iss_vl, iss_last, iss_idx, done, err
  );

endinterface

// File: rtl/vlmax_calc.sv
// vlmax_calc: combinational VLMAX = (VLEN >> (sew + 3)) << lmul.
//   sew_i, lmul_i : encoded vtype fields
//   vlmax_o       : VLMAX in OUT_W bits, 0 when the encoding is illegal
//   legal_o       : both fields legal
// Shared with the CSR read path, so it carries no state.
module vlmax_calc
  import vl_pkg::*;
#(
  parameter int unsigned VLEN  = VlenDefault,
  parameter int unsigned OUT_W = 9
) (
  input  logic [VtypeFieldW-1:0] sew_i,
  input  logic [VtypeFieldW-1:0] lmul_i,
  output logic [OUT_W-1:0]       vlmax_o,
  output logic                   legal_o
);

  logic [31:0] vlmax_full;

  always_comb begin
    legal_o    = sew_legal(sew_i) && lmul_legal(lmul_i);
    vlmax_full = '0;
    if (legal_o) begin
      vlmax_full = (32'(VLEN) >> (32'(sew_i) + 32'd3)) << lmul_i;
    end
    vlmax_o = vlmax_full[OUT_W-1:0];
  end

endmodule

// File: rtl/vl_strip_sequencer.sv
// vl_strip_sequencer: strip-mining controller for the vector unit.
// Accepts one (SEW, LMUL, AVL) request, computes VLMAX and issues strips of
// vl = min(rem, VLMAX) one per handshake until AVL is exhausted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort, present only when VL_SEQ_FLUSH_EN is defined
//   bus        : vl_strip_sequencer_if.slave (req_*, iss_*, done, err)
// Optional feature macro: VL_SEQ_FLUSH_EN.
module vl_strip_sequencer
  import vl_pkg::*;
#(
  parameter int unsigned VLEN  = VlenDefault,
  parameter int unsigned AVL_W = 8,
  parameter int unsigned IDX_W = 4
) (
  input logic clk,
  input logic rst_n,
`ifdef VL_SEQ_FLUSH_EN
  input logic flush,
`endif
  vl_strip_sequencer_if.slave bus
);

  if (VLEN < 64 || VLEN > 256 || (VLEN & (VLEN - 1)) != 0) begin : g_bad_vlen
    $error("VLEN must be a power of two in 64..256");
  end
  // e8/m8 yields VLMAX == VLEN, which must fit the AVL_W+1 bit vlmax register.
  if ((VLEN >> (AVL_W + 1)) != 0) begin : g_bad_avl_w
    $error("VLEN does not fit in AVL_W+1 bits");
  end

  logic flush_w;
`ifdef VL_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  vl_state_e        state_q, state_d;
  logic [AVL_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AVL_W:0]   vlmax_q, vlmax_d;

  logic             iss_valid_q, iss_valid_d;
  logic [AVL_W-1:0] iss_vl_q, iss_vl_d;
  logic             iss_last_q, iss_last_d;
  logic [IDX_W-1:0] iss_idx_q, iss_idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [AVL_W:0]   req_vlmax;
  logic             req_legal;
  logic             req_ready;
  logic             accept;
  logic             iss_fire;
  logic             fits;

  vlmax_calc #(
    .VLEN  (VLEN),
    .OUT_W (AVL_W + 1)
  ) u_vlmax_calc (
    .sew_i   (bus.req_sew),
    .lmul_i  (bus.req_lmul),
    .vlmax_o (req_vlmax),
    .legal_o (req_legal)
  );

  // State-only decode; rst_n gating keeps ready low while held in reset.
  assign req_ready = rst_n && (state_q == StIdle) && !flush_w;
  assign accept    = bus.req_valid && req_ready;
  assign iss_fire  = iss_valid_q && bus.iss_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    vlmax_d = vlmax_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (flush_w) begin
      // Abort wins over any handshake in the same cycle; no done pulse.
      state_d = StIdle;
      rem_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            vlmax_d = req_vlmax;
            idx_d   = '0;
            rem_d   = req_legal ? bus.req_avl : '0;
            if (!req_legal) begin
              err_d = 1'b1;
            end else if (bus.req_avl == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StIssue;
            end
          end
        end
        StIssue: begin
          if (iss_fire) begin
            // iss_vl_q <= rem_q by construction, so no underflow.
            rem_d = rem_q - iss_vl_q;
            idx_d = idx_q + 1'b1;
            if (iss_last_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Strip outputs are registered: derive them from next-state values.
    fits        = ({1'b0, rem_d} <= vlmax_d);
    iss_valid_d = (state_d == StIssue);
    iss_vl_d    = '0;
    iss_last_d  = 1'b0;
    iss_idx_d   = '0;
    if (iss_valid_d) begin
      iss_vl_d   = fits ? rem_d : vlmax_d[AVL_W-1:0];
      iss_last_d = fits;
      iss_idx_d  = idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      idx_q       <= '0;
      vlmax_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_vl_q    <= '0;
      iss_last_q  <= 1'b0;
      iss_idx_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      vlmax_q     <= vlmax_d;
      iss_valid_q <= iss_valid_d;
      iss_vl_q    <= iss_vl_d;
      iss_last_q  <= iss_last_d;
      iss_idx_q   <= iss_idx_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_vl    = iss_vl_q;
  assign bus.iss_last  = iss_last_q;
  assign bus.iss_idx   = iss_idx_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_vl_strip_sequencer.sv
// tb_vl_strip_sequencer: scoreboard bench for vl_strip_sequencer (VLEN=64).
// Expected strips/events are queued when a request is driven and popped by a
// negedge monitor. Flush scenario is built when VL_SEQ_FLUSH_EN is defined.
module tb_vl_strip_sequencer;

  localparam int unsigned VLEN  = 64;
  localparam int unsigned AVL_W = 8;
  localparam int unsigned IDX_W = 4;

  typedef struct {
    int unsigned vl;
    int unsigned last;
    int unsigned idx;
  } strip_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef VL_SEQ_FLUSH_EN
  logic flush = 1'b0;
`endif

  vl_strip_sequencer_if #(.AVL_W(AVL_W), .IDX_W(IDX_W)) bus ();

  vl_strip_sequencer #(
    .VLEN  (VLEN),
    .AVL_W (AVL_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef VL_SEQ_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  strip_t      exp_q[$];
  int unsigned evt_q[$];   // 1 = done, 2 = err

  int          acc_cyc     = -10;
  int          last_hs_cyc = -20;
  logic        prev_valid  = 1'b0;
  logic        prev_ready  = 1'b0;
  int unsigned prev_vl, prev_last, prev_idx;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples at negedge, well away from the driving edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.done || bus.err) begin
        if (evt_q.size() == 0) begin
          check_eq("spurious_evt", {bus.err, bus.done}, 0);
        end else begin
          check_eq("evt", {30'd0, bus.err, bus.done}, evt_q.pop_front());
          check_eq("evt_lat", cyc, (last_hs_cyc > acc_cyc) ? last_hs_cyc + 1 : acc_cyc + 1);
          if (bus.done) check_eq("rdy_at_done", bus.req_ready, 1);
        end
      end
      if (bus.iss_valid && !prev_valid) check_eq("first_lat", cyc, acc_cyc + 1);
      if (bus.iss_valid && prev_valid && !prev_ready) begin
        check_eq("hold_vl", bus.iss_vl, prev_vl);
        check_eq("hold_last", bus.iss_last, prev_last);
        check_eq("hold_idx", bus.iss_idx, prev_idx);
      end
      if (bus.iss_valid && bus.iss_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_strip", bus.iss_vl, 0);
        end else begin
          strip_t e;
          e = exp_q.pop_front();
          check_eq("strip_vl", bus.iss_vl, e.vl);
          check_eq("strip_last", bus.iss_last, e.last);
          check_eq("strip_idx", bus.iss_idx, e.idx);
        end
        last_hs_cyc = cyc;
      end
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      prev_valid = bus.iss_valid;
      prev_ready = bus.iss_ready;
      prev_vl    = bus.iss_vl;
      prev_last  = bus.iss_last;
      prev_idx   = bus.iss_idx;
    end
  end

  // Reference model: VLMAX = VLEN * 2^lmul / (8 * 2^sew).
  task automatic push_expected(input int unsigned sew, input int unsigned lmul,
                               input int unsigned avl);
    int unsigned vlmax, rem, k;
    strip_t s;
    if (sew > 3 || lmul > 3) begin
      evt_q.push_back(2);
    end else if (avl == 0) begin
      evt_q.push_back(1);
    end else begin
      vlmax = (VLEN * (1 << lmul)) / (8 << sew);
      rem = avl;
      k = 0;
      while (rem > 0) begin
        s.vl   = (rem < vlmax) ? rem : vlmax;
        s.last = (rem <= vlmax) ? 1 : 0;
        s.idx  = k % (1 << IDX_W);
        exp_q.push_back(s);
        rem -= s.vl;
        k++;
      end
      evt_q.push_back(1);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send_req(input int unsigned sew, input int unsigned lmul,
                          input int unsigned avl);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!bus.req_ready) check_eq("req_ready_timeout", bus.req_ready, 1);
    push_expected(sew, lmul, avl);
    bus.req_valid = 1'b1;
    bus.req_sew   = 3'(sew);
    bus.req_lmul  = 3'(lmul);
    bus.req_avl   = 8'(avl);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("drain", exp_q.size() + evt_q.size(), 0);
    repeat (2) begin @(posedge clk); #2; end
  endtask

  task automatic wait_strip1();
    int n = 0;
    while (!(bus.iss_valid && bus.iss_idx == 1) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("reach_strip1", bus.iss_idx, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, bus.req_ready, 0);
    check_eq({tag, "_valid"}, bus.iss_valid, 0);
    check_eq({tag, "_vl"}, bus.iss_vl, 0);
    check_eq({tag, "_last"}, bus.iss_last, 0);
    check_eq({tag, "_idx"}, bus.iss_idx, 0);
    check_eq({tag, "_done"}, bus.done, 0);
    check_eq({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_sew   = '0;
    bus.req_lmul  = '0;
    bus.req_avl   = '0;
    bus.iss_ready = 1'b1;

    #3;
    check_all_zero("reset");
    #14;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_eq("ready_after_reset", bus.req_ready, 1);

    // e8/m1, AVL=20: 8,8,4.
    send_req(0, 0, 20);
    wait_drain();

    // e64/m8, AVL=8: single strip, then a back-to-back request.
    send_req(3, 3, 8);
    send_req(0, 0, 5);
    wait_drain();

    // Illegal SEW: err only, ready stays high.
    send_req(4, 0, 10);
    for (int i = 0; i < 3; i++) begin
      check_eq("err_no_valid", bus.iss_valid, 0);
      check_eq("err_ready", bus.req_ready, 1);
      @(posedge clk); #2;
    end
    wait_drain();

    // Illegal LMUL (fractional).
    send_req(0, 5, 10);
    wait_drain();

    // AVL=0, e32/m2: done only.
    send_req(2, 1, 0);
    wait_drain();

    // e16/m4, AVL=40 with a 3-cycle stall on strip 1.
    send_req(1, 2, 40);
    wait_strip1();
    bus.iss_ready = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    check_eq("stall_vl", bus.iss_vl, 16);
    check_eq("stall_idx", bus.iss_idx, 1);
    bus.iss_ready = 1'b1;
    wait_drain();

    // Index wrap: e8/m1, AVL=140 -> 18 strips, idx wraps at 16.
    send_req(0, 0, 140);
    wait_drain();

    // Reset mid-request: everything drops immediately, no done.
    send_req(1, 2, 40);
    wait_strip1();
    bus.iss_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    evt_q.delete();
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_rerelease", bus.req_ready, 1);
    @(posedge clk); #2;
    bus.iss_ready = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    check_eq("midreset_no_valid", bus.iss_valid, 0);
    send_req(2, 0, 3);
    wait_drain();

`ifdef VL_SEQ_FLUSH_EN
    // Flush during strip 1: idle next cycle, no done.
    send_req(1, 2, 40);
    wait_strip1();
    flush = 1'b1;
    check_eq("flush_blocks_ready", bus.req_ready, 0);
    @(posedge clk); #2;
    flush = 1'b0;
    exp_q.delete();
    evt_q.delete();
    check_eq("flush_valid", bus.iss_valid, 0);
    check_eq("flush_ready", bus.req_ready, 1);
    repeat (3) begin @(posedge clk); #2; end
    send_req(0, 0, 9);
    wait_drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
